// File: rtl/dmem_pkg.sv
// Shared FSM encoding, default parameters and address-check helper for the
// data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam int DEF_DEPTH        = 64;
    localparam int DEF_WAIT_CYCLES  = 2;
    localparam int DEF_MAILBOX_ADDR = 84;
    localparam int DEF_PASS_VALUE   = 7;

    // Wait-state counter holds 0..15.
    localparam int CNT_W = 4;

    // Misaligned byte address or word index past the end of the array.
    function automatic logic addr_err(input logic [31:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Processor-side request/response bus of the data-memory responder, plus
// the sticky mailbox status flags.
interface dmem_responder_if;

    logic        req_valid;
    logic        memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] readdata;
    logic        err;
    logic        done;
    logic        pass;

    modport master (
        output req_valid, memwrite, dataadr, writedata,
        input  req_ready, resp_valid, readdata, err, done, pass
    );

    modport slave (
        input  req_valid, memwrite, dataadr, writedata,
        output req_ready, resp_valid, readdata, err, done, pass
    );

endinterface

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: synchronous write, combinational read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states and
// a sticky pass/fail mailbox word.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH        = DEF_DEPTH,
    parameter int WAIT_CYCLES  = DEF_WAIT_CYCLES,
    parameter int MAILBOX_ADDR = DEF_MAILBOX_ADDR,
    parameter int PASS_VALUE   = DEF_PASS_VALUE
) (
    input  logic              clk,
    input  logic              reset,
    dmem_responder_if.slave   bus
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] WAIT_LD = CNT_W'(WAIT_CYCLES);

    state_t           r_state, w_state_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;

    logic             r_we;
    logic             r_err;
    logic [31:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_done;
    logic             r_pass;

    logic             w_accept;
    logic             w_commit;
    logic             w_mbox_hit;
    logic [31:0]      w_rdata;

    assign w_accept   = (r_state == ST_IDLE) && bus.req_valid;
    assign w_mbox_hit = (r_addr == 32'(MAILBOX_ADDR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // The counter reaching zero on an edge is what moves WAIT into RESP, so
    // WAIT lasts WAIT_CYCLES cycles and RESP follows one cycle later.
    always_comb begin
        w_state_nx     = r_state;
        w_cnt_nx       = r_cnt;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        bus.readdata   = '0;
        bus.err        = 1'b0;
        w_commit       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nx = ST_RESP;
                    end else begin
                        w_state_nx = ST_WAIT;
                        w_cnt_nx   = WAIT_LD;
                    end
                end
            end
            ST_WAIT: begin
                w_cnt_nx = r_cnt - 1'b1;
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                bus.resp_valid = 1'b1;
                bus.err        = r_err;
                bus.readdata   = (!r_err && !r_we) ? w_rdata : '0;
                w_commit       = r_we && !r_err;
                w_state_nx     = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // Request is captured once at accept; the bus may change freely afterwards.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_we    <= bus.memwrite;
            r_err   <= addr_err(bus.dataadr, DEPTH);
            r_addr  <= bus.dataadr;
            r_wdata <= bus.writedata;
        end
    end

    // Only the first good mailbox store is recorded.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else if (w_commit && w_mbox_hit && !r_done) begin
            r_done <= 1'b1;
            r_pass <= (r_wdata == 32'(PASS_VALUE));
        end
    end

    assign bus.done = r_done;
    assign bus.pass = r_pass;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .i_we    (w_commit),
        .i_waddr (r_addr[AW+1:2]),
        .i_wdata (r_wdata),
        .i_raddr (r_addr[AW+1:2]),
        .o_rdata (w_rdata)
    );

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter DEPTH, default 64, giving the number of 32-bit words stored.
REQ-002 The module SHALL have parameter WAIT_CYCLES, default 2, giving the wait states inserted per access (legal range 0..15).
REQ-003 The module SHALL have parameter MAILBOX_ADDR, default 84, giving the byte address of the status mailbox.
REQ-004 The module SHALL have parameter PASS_VALUE, default 7, giving the mailbox value that signals success.
REQ-005 The module SHALL have one clock, and its reset SHALL be asynchronous and active-low.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous, active-low reset.
REQ-008 req_valid  input  1  processor presents a request.
REQ-009 memwrite  input  1  request is a store (1) or a load (0); sampled with req_valid.
REQ-010 dataadr  input  32  byte address.
REQ-011 writedata  input  32  store data.
REQ-012 req_ready  output  1  responder can accept a request.
REQ-013 resp_valid  output  1  one-cycle completion pulse.
REQ-014 readdata  output  32  load data; valid only while resp_valid is high.
REQ-015 err  output  1  request failed; valid only while resp_valid is high.
REQ-016 done  output  1  sticky flag: a mailbox store has occurred.
REQ-017 pass  output  1  sticky flag: the first mailbox store carried PASS_VALUE.

Function
REQ-018 The controller SHALL be a three-state FSM: IDLE, WAIT, RESP.
REQ-019 IDLE: req_ready SHALL be 1; a request SHALL be accepted on a rising edge where req_valid and req_ready are both 1, latching memwrite, dataadr and writedata.
REQ-020 On accept, the FSM SHALL go to WAIT with the counter loaded to WAIT_CYCLES; if WAIT_CYCLES is 0, it SHALL go directly to RESP.
REQ-021 WAIT: the counter SHALL decrement each cycle, and the FSM SHALL go to RESP on the edge where the counter reaches 0.
REQ-022 RESP: resp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-023 resp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge.
REQ-024 req_ready SHALL be 0 in WAIT and RESP; requests presented then SHALL be ignored, not queued.
REQ-025 Back-to-back throughput SHALL be one request every WAIT_CYCLES+2 cycles.
REQ-026 The word index SHALL be dataadr[31:2]; a request SHALL be erroneous if dataadr[1:0] != 0 or the index is >= DEPTH.
REQ-027 A valid store SHALL write the array at the edge ending RESP; a valid load SHALL drive readdata = mem[index] during RESP.
REQ-028 An erroneous request SHALL leave memory and the mailbox flags unchanged, and SHALL respond with err=1 and readdata=0.
REQ-029 Outside RESP, readdata SHALL be 0 and err SHALL be 0.
REQ-030 A valid store to MAILBOX_ADDR SHALL also be written to memory.
REQ-031 On the first such store, done SHALL be set to 1 and pass SHALL be set to (writedata == PASS_VALUE), both at the edge ending RESP.
REQ-032 Later mailbox stores SHALL NOT change done or pass.
REQ-033 A load of a word stored in the same cycle SHALL be impossible by construction, because only one request is in flight at a time.

Reset
REQ-034 Asserting reset low at any time, including mid-WAIT or during RESP, SHALL immediately force: FSM to IDLE, counter 0, req_ready 1, resp_valid 0, readdata 0, err 0, done 0, pass 0.
REQ-035 An in-flight store SHALL be dropped when reset is asserted.
REQ-036 Memory contents SHALL NOT be reset and are undefined after power-up.

Structure
REQ-037 The FSM state encodings and the default parameter constants SHALL live in the shared package dmem_pkg.
REQ-038 The storage array SHALL be a sub-module, dmem_array: synchronous write, combinational read, DEPTH x 32.

Verification
REQ-039 Store then load: store 0x0000_0005 to address 80, then load address 80 -> readdata=5, err=0; resp_valid at exactly cycle 3 after each accept (WAIT_CYCLES=2).
REQ-040 Mailbox pass: store 7 to address 84 -> done=1 and pass=1 after RESP; a second store of 3 to address 84 -> pass stays 1, and load 84 returns 3.
REQ-041 Mailbox fail: store 9 to address 84 -> done=1, pass=0.
REQ-042 Errors: store to address 0x52 -> err=1, memory unchanged; load from address 256 (DEPTH=64) -> err=1, readdata=0.
REQ-043 Busy and timing: hold req_valid high continuously -> accepts spaced exactly 4 cycles apart, no requests lost or duplicated.
REQ-044 Reset mid-operation: assert reset during WAIT of a store to address 84 -> resp_valid never pulses, done=0, req_ready=1 immediately, and a subsequent load of 84 is not the aborted value.
REQ-045 WAIT_CYCLES=0: resp_valid rises 1 cycle after accept.
